// File: rtl/cr_prefix_fe_seq_pkg.sv
// Shared types and defaults for the prefix feature-extraction sequencer.
package cr_prefix_fe_seq_pkg;

  localparam int N_CMP_DEF   = 16;
  localparam int PFX_LEN_DEF = 64;

  // Field order matches the config memory word.
  typedef struct packed {
    logic       use_prior;
    logic       no_delay;
    logic [1:0] cmp_type;
    logic [7:0] match_val;
  } prefix_fe_cfg_t;

  typedef enum logic [1:0] {F_IDLE, F_FEED, F_SKIP} fe_seq_frm_st_e;
  typedef enum logic [1:0] {L_IDLE, L_RD, L_WAIT}   fe_seq_ld_st_e;

endpackage

// File: rtl/cr_prefix_fe_seq_if.sv
// Input byte stream and config memory read port of the prefix sequencer.
interface cr_prefix_fe_seq_if #(
  parameter int N_CMP = 16
);
  localparam int AW = (N_CMP > 1) ? $clog2(N_CMP) : 1;

  logic          in_vld;
  logic          in_rdy;
  logic [7:0]    in_data;
  logic          in_sof;
  logic          in_eof;
  logic          cfg_rd_en;
  logic [AW-1:0] cfg_rd_addr;
  logic [11:0]   cfg_rd_data;

  modport master (
    output in_vld, in_data, in_sof, in_eof, cfg_rd_data,
    input  in_rdy, cfg_rd_en, cfg_rd_addr
  );

  modport slave (
    input  in_vld, in_data, in_sof, in_eof, cfg_rd_data,
    output in_rdy, cfg_rd_en, cfg_rd_addr
  );
endinterface

// File: rtl/cr_prefix_fe_cfg_bank.sv
// Shadow and active compare-config banks; the whole shadow bank moves to the
// active bank on a single swap strobe.
module cr_prefix_fe_cfg_bank
  import cr_prefix_fe_seq_pkg::*;
#(
  parameter int N_CMP = N_CMP_DEF,
  parameter int AW    = (N_CMP > 1) ? $clog2(N_CMP) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_wr_en,
  input  logic [AW-1:0]        i_wr_addr,
  input  prefix_fe_cfg_t       i_wr_data,
  input  logic                 i_swap,
  output logic [N_CMP*8-1:0]   o_match_val,
  output logic [N_CMP*2-1:0]   o_cmp_type,
  output logic [N_CMP-1:0]     o_use_prior,
  output logic [N_CMP-1:0]     o_no_delay
);

  prefix_fe_cfg_t r_shadow [N_CMP];
  prefix_fe_cfg_t r_active [N_CMP];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_CMP; i++) r_shadow[i] <= '0;
    end else if (i_wr_en) begin
      r_shadow[i_wr_addr] <= i_wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_CMP; i++) r_active[i] <= '0;
    end else if (i_swap) begin
      for (int i = 0; i < N_CMP; i++) r_active[i] <= r_shadow[i];
    end
  end

  always_comb begin
    o_match_val = '0;
    o_cmp_type  = '0;
    o_use_prior = '0;
    o_no_delay  = '0;
    for (int i = 0; i < N_CMP; i++) begin
      o_match_val[8*i +: 8] = r_active[i].match_val;
      o_cmp_type[2*i +: 2]  = r_active[i].cmp_type;
      o_use_prior[i]        = r_active[i].use_prior;
      o_no_delay[i]         = r_active[i].no_delay;
    end
  end

endmodule

// File: rtl/cr_prefix_fe_seq.sv
// Prefix feature-extraction sequencer: config loader, between-frame bank swap
// and frame FSM feeding the first PFX_LEN bytes of each frame to the cells.
//
// state  | meaning
// L_IDLE | loader waiting for cfg_ld
// L_RD   | issuing one config read per cycle
// L_WAIT | last read data arriving, then swap pending
// F_IDLE | between frames, waiting for sof
// F_FEED | bytes go to the compare cells
// F_SKIP | prefix full, remaining bytes dropped until eof
module cr_prefix_fe_seq
  import cr_prefix_fe_seq_pkg::*;
#(
  parameter int N_CMP   = N_CMP_DEF,
  parameter int PFX_LEN = PFX_LEN_DEF
) (
  input  logic                          clk,
  input  logic                          rst_n,
  cr_prefix_fe_seq_if.slave             bus,
  input  logic                          i_cfg_ld,
  output logic                          o_cfg_busy,
  output logic [7:0]                    o_char,
  output logic                          o_char_valid,
  output logic [N_CMP*8-1:0]            o_match_val,
  output logic [N_CMP*2-1:0]            o_cmp_type,
  output logic [N_CMP-1:0]              o_use_prior,
  output logic [N_CMP-1:0]              o_no_delay,
  output logic [$clog2(PFX_LEN+1)-1:0]  o_pfx_cnt,
  output logic                          o_frame_done,
  output logic                          o_sof_err
);

  localparam int AW = (N_CMP > 1) ? $clog2(N_CMP) : 1;
  localparam int CW = $clog2(PFX_LEN+1);

  fe_seq_ld_st_e  r_ld_st, w_ld_st;
  fe_seq_frm_st_e r_frm_st, w_frm_st;
  logic [AW-1:0]  r_addr, w_addr, r_wr_addr;
  logic           r_pend, w_pend, r_rd_vld;
  logic           w_busy, w_swap, w_rdy, w_acc;
  logic [7:0]     r_char, w_char;
  logic           r_cv, w_cv, r_done, w_done, r_serr, w_serr;
  logic [CW-1:0]  r_cnt, w_cnt;

  assign w_busy = (r_ld_st != L_IDLE) | r_pend;
  assign w_swap = r_pend & (r_frm_st == F_IDLE);
  assign w_rdy  = !((r_frm_st == F_IDLE) && w_busy);
  assign w_acc  = bus.in_vld & w_rdy;

  assign bus.in_rdy      = w_rdy;
  assign bus.cfg_rd_en   = (r_ld_st == L_RD);
  assign bus.cfg_rd_addr = r_addr;
  assign o_cfg_busy      = w_busy;
  assign o_char          = r_char;
  assign o_char_valid    = r_cv;
  assign o_pfx_cnt       = r_cnt;
  assign o_frame_done    = r_done;
  assign o_sof_err       = r_serr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ld_st   <= L_IDLE;
      r_addr    <= '0;
      r_pend    <= 1'b0;
      r_rd_vld  <= 1'b0;
      r_wr_addr <= '0;
    end else begin
      r_ld_st   <= w_ld_st;
      r_addr    <= w_addr;
      r_pend    <= w_pend;
      r_rd_vld  <= (r_ld_st == L_RD);
      r_wr_addr <= r_addr;
    end
  end

  always_comb begin
    w_ld_st = r_ld_st;
    w_addr  = r_addr;
    w_pend  = r_pend;
    case (r_ld_st)
      L_IDLE: if (i_cfg_ld && !r_pend) begin
        w_ld_st = L_RD;
        w_addr  = '0;
      end
      L_RD: begin
        if (r_addr == AW'(N_CMP-1)) w_ld_st = L_WAIT;
        else                        w_addr  = r_addr + AW'(1);
      end
      L_WAIT: begin
        w_pend  = 1'b1;
        w_ld_st = L_IDLE;
        w_addr  = '0;
      end
      default: w_ld_st = L_IDLE;
    endcase
    if (w_swap) w_pend = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frm_st <= F_IDLE;
      r_char   <= '0;
      r_cv     <= 1'b0;
      r_cnt    <= '0;
      r_done   <= 1'b0;
      r_serr   <= 1'b0;
    end else begin
      r_frm_st <= w_frm_st;
      r_char   <= w_char;
      r_cv     <= w_cv;
      r_cnt    <= w_cnt;
      r_done   <= w_done;
      r_serr   <= w_serr;
    end
  end

  // pfx_cnt only advances in F_FEED, where it is always below PFX_LEN.
  always_comb begin
    w_frm_st = r_frm_st;
    w_char   = r_char;
    w_cv     = 1'b0;
    w_cnt    = r_cnt;
    w_done   = 1'b0;
    w_serr   = 1'b0;
    case (r_frm_st)
      F_IDLE: if (w_acc) begin
        if (bus.in_sof) begin
          w_char = bus.in_data;
          w_cv   = 1'b1;
          w_cnt  = CW'(1);
          if (bus.in_eof)        w_done   = 1'b1;
          else if (PFX_LEN == 1) w_frm_st = F_SKIP;
          else                   w_frm_st = F_FEED;
        end else begin
          w_serr = 1'b1;
        end
      end
      F_FEED: if (w_acc) begin
        w_char = bus.in_data;
        w_cv   = 1'b1;
        w_cnt  = r_cnt + CW'(1);
        if (bus.in_eof) begin
          w_done   = 1'b1;
          w_frm_st = F_IDLE;
        end else if (r_cnt + CW'(1) == CW'(PFX_LEN)) begin
          w_frm_st = F_SKIP;
        end
      end
      F_SKIP: if (w_acc && bus.in_eof) begin
        w_done   = 1'b1;
        w_frm_st = F_IDLE;
      end
      default: w_frm_st = F_IDLE;
    endcase
  end

  cr_prefix_fe_cfg_bank #(.N_CMP(N_CMP), .AW(AW)) u_bank (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_wr_en     (r_rd_vld),
    .i_wr_addr   (r_wr_addr),
    .i_wr_data   (prefix_fe_cfg_t'(bus.cfg_rd_data)),
    .i_swap      (w_swap),
    .o_match_val (o_match_val),
    .o_cmp_type  (o_cmp_type),
    .o_use_prior (o_use_prior),
    .o_no_delay  (o_no_delay)
  );

endmodule

// File: tb/tb_cr_prefix_fe_seq.sv
// Directed bench for cr_prefix_fe_seq: load, frames, mid-frame swap, errors, reset.
module tb_cr_prefix_fe_seq;
  import cr_prefix_fe_seq_pkg::*;

  localparam int N  = 16;
  localparam int PL = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cr_prefix_fe_seq_if #(.N_CMP(N)) bus();

  logic           cfg_ld = 1'b0;
  logic           busy, cv, done, serr;
  logic [7:0]     ch;
  logic [N*8-1:0] mv;
  logic [N*2-1:0] ct;
  logic [N-1:0]   up, nd;
  logic [6:0]     cnt;
  logic           mem_sel = 1'b0;

  cr_prefix_fe_seq #(.N_CMP(N), .PFX_LEN(PL)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave), .i_cfg_ld(cfg_ld),
    .o_cfg_busy(busy), .o_char(ch), .o_char_valid(cv), .o_match_val(mv),
    .o_cmp_type(ct), .o_use_prior(up), .o_no_delay(nd), .o_pfx_cnt(cnt),
    .o_frame_done(done), .o_sof_err(serr)
  );

  function automatic logic [11:0] mem_val(input int a, input logic sel);
    logic [11:0] v;
    v = (a == 3) ? 12'h2A5 : 12'(a * 12'h111);
    return sel ? ~v : v;
  endfunction

  always @(posedge clk or negedge rst_n)
    if (!rst_n) bus.cfg_rd_data <= '0;
    else if (bus.cfg_rd_en) bus.cfg_rd_data <= mem_val(int'(bus.cfg_rd_addr), mem_sel);

  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_bank(input logic sel, input string tag);
    logic [11:0] e;
    for (int i = 0; i < N; i++) begin
      e = mem_val(i, sel);
      chk($sformatf("%s match%0d", tag, i), 64'(mv[8*i +: 8]), 64'(e[7:0]));
      chk($sformatf("%s type%0d", tag, i),  64'(ct[2*i +: 2]), 64'(e[9:8]));
      chk($sformatf("%s nodly%0d", tag, i), 64'(nd[i]), 64'(e[10]));
      chk($sformatf("%s prior%0d", tag, i), 64'(up[i]), 64'(e[11]));
    end
  endtask

  // Drives one frame back-to-back, honouring in_rdy, and tallies what comes out.
  task automatic send_frame(input int len, input logic [7:0] base, input int ld_at,
                            output int nval, output int ndone, output int lag,
                            output int nbadc, output int nstall, output int first_acc,
                            output int chg_at, output int done_wv);
    int b, fed, eof_c;
    logic acc;
    logic [N*8-1:0] snap;
    b = 0; fed = 0; eof_c = -1; ndone = 0; lag = -1; nbadc = 0; nstall = 0;
    first_acc = -1; chg_at = -1; done_wv = 0; snap = mv;
    for (int c = 0; c < len + 60; c++) begin
      cfg_ld = (c == ld_at);
      if (b < len) begin
        bus.in_vld = 1'b1; bus.in_data = base + 8'(b);
        bus.in_sof = (b == 0); bus.in_eof = (b == len - 1);
      end else begin
        bus.in_vld = 1'b0; bus.in_sof = 1'b0; bus.in_eof = 1'b0;
      end
      acc = bus.in_vld && bus.in_rdy;
      if (bus.in_vld && !bus.in_rdy) nstall++;
      if (acc && b == 0) first_acc = c;
      if (acc && b == len - 1) eof_c = c;
      step();
      if (acc) b++;
      if (cv) begin
        if (ch !== base + 8'(fed)) nbadc++;
        fed++;
      end
      if (mv !== snap && chg_at < 0) chg_at = c + 1;
      if (done) begin
        ndone++;
        lag = c + 1 - eof_c;
        if (cv) done_wv++;
      end
      if (done && b == len) break;
    end
    cfg_ld = 1'b0;
    nval = fed;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n_rd, first_rd, nval, ndone, lag, nbadc, nstall, facc, chg, dwv;
    logic found;
    bus.in_vld = 1'b0; bus.in_data = '0; bus.in_sof = 1'b0; bus.in_eof = 1'b0;

    // reset state
    step(); step();
    chk("rst char_valid", 64'(cv), 0);
    chk("rst char", 64'(ch), 0);
    chk("rst frame_done", 64'(done), 0);
    chk("rst sof_err", 64'(serr), 0);
    chk("rst pfx_cnt", 64'(cnt), 0);
    chk("rst busy", 64'(busy), 0);
    chk("rst rd_en", 64'(bus.cfg_rd_en), 0);
    chk("rst rd_addr", 64'(bus.cfg_rd_addr), 0);
    chk("rst banks", 64'(|{mv, ct, up, nd}), 0);
    rst_n = 1'b1;
    step();
    chk("idle in_rdy", 64'(bus.in_rdy), 1);

    // config load with a second, ignored cfg_ld at offset 5
    cfg_ld = 1'b1; n_rd = 0; first_rd = -1;
    for (int off = 1; off <= 22; off++) begin
      step();
      if (bus.cfg_rd_en) begin
        if (first_rd < 0) first_rd = off;
        chk($sformatf("rd_addr #%0d", n_rd), 64'(bus.cfg_rd_addr), 64'(n_rd));
        n_rd++;
      end
      if (off == 18) begin
        chk("pre-swap match3", 64'(mv[31:24]), 0);
        chk("busy while pending", 64'(busy), 1);
        chk("rdy low while pending", 64'(bus.in_rdy), 0);
      end
      if (off == 19) begin
        chk("entry3 match", 64'(mv[31:24]), 64'h0A5);
        chk("entry3 type", 64'(ct[7:6]), 2);
        check_bank(1'b0, "load");
        chk("busy after swap", 64'(busy), 0);
      end
      cfg_ld = (off == 5);
    end
    chk("read count", 64'(n_rd), 16);
    chk("first read offset", 64'(first_rd), 1);

    // 100-byte frame, then single-beat frame directly behind it
    send_frame(100, 8'h00, -1, nval, ndone, lag, nbadc, nstall, facc, chg, dwv);
    chk("long fed", 64'(nval), 64);
    chk("long done count", 64'(ndone), 1);
    chk("long done lag", 64'(lag), 1);
    chk("long char data", 64'(nbadc), 0);
    chk("long stalls", 64'(nstall), 0);
    chk("long pfx_cnt", 64'(cnt), 64);

    send_frame(1, 8'h41, -1, nval, ndone, lag, nbadc, nstall, facc, chg, dwv);
    chk("single fed", 64'(nval), 1);
    chk("single char", 64'(ch), 64'h41);
    chk("single done", 64'(ndone), 1);
    chk("single done with valid", 64'(dwv), 1);
    chk("single stalls", 64'(nstall), 0);
    chk("single pfx_cnt", 64'(cnt), 1);
    bus.in_vld = 1'b0; bus.in_sof = 1'b0; bus.in_eof = 1'b0;
    step();
    chk("single valid drop", 64'(cv), 0);
    chk("single char hold", 64'(ch), 64'h41);
    chk("single pfx_cnt hold", 64'(cnt), 1);

    // cfg_ld mid-frame: swap deferred until after eof, next sof waits for it
    mem_sel = 1'b1;
    send_frame(10, 8'h10, 2, nval, ndone, lag, nbadc, nstall, facc, chg, dwv);
    chk("midA bank stable", 64'(chg), 64'hFFFF_FFFF_FFFF_FFFF);
    chk("midA fed", 64'(nval), 10);
    chk("midA stalls", 64'(nstall), 0);
    chk("midA data", 64'(nbadc), 0);
    chk("midA rdy low idle", 64'(bus.in_rdy), 0);
    send_frame(4, 8'h80, -1, nval, ndone, lag, nbadc, nstall, facc, chg, dwv);
    chk("midB stalls", 64'(nstall), 11);
    chk("midB first accept", 64'(facc), 11);
    chk("midB bank change", 64'(chg), 11);
    chk("midB fed", 64'(nval), 4);
    chk("midB data", 64'(nbadc), 0);
    chk("midB pfx_cnt", 64'(cnt), 4);
    chk("swap entry3 match", 64'(mv[31:24]), 64'h05A);
    check_bank(1'b1, "swap");

    // non-sof byte while idle
    bus.in_vld = 1'b1; bus.in_sof = 1'b0; bus.in_eof = 1'b0; bus.in_data = 8'h55;
    step();
    bus.in_vld = 1'b0;
    chk("sof_err pulse", 64'(serr), 1);
    chk("sof_err no valid", 64'(cv), 0);
    chk("sof_err char hold", 64'(ch), 64'h83);
    step();
    chk("sof_err one cycle", 64'(serr), 0);
    chk("sof_err idle rdy", 64'(bus.in_rdy), 1);

    // reset during load at entry 7
    mem_sel = 1'b0;
    cfg_ld = 1'b1; found = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      step();
      cfg_ld = 1'b0;
      if (bus.cfg_rd_en && bus.cfg_rd_addr == 4'd7) found = 1'b1;
    end
    chk("reached entry 7", 64'(found), 1);
    rst_n = 1'b0;
    #1;
    chk("mid-rst rd_en", 64'(bus.cfg_rd_en), 0);
    chk("mid-rst rd_addr", 64'(bus.cfg_rd_addr), 0);
    chk("mid-rst busy", 64'(busy), 0);
    chk("mid-rst pfx_cnt", 64'(cnt), 0);
    chk("mid-rst char", 64'(ch), 0);
    chk("mid-rst banks", 64'(|{mv, ct, up, nd}), 0);
    step();
    rst_n = 1'b1;
    step(); step(); step();
    chk("post-rst banks", 64'(|{mv, ct, up, nd}), 0);
    chk("post-rst busy", 64'(busy), 0);
    chk("post-rst rd_en", 64'(bus.cfg_rd_en), 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/cr_prefix_fe_seq.md
# cr_prefix_fe_seq

Sequencer for the prefix feature-extraction compare array. It loads per-cell compare configuration from a config memory into a shadow bank. It swaps that bank into the active bank only between frames. It feeds the first PFX_LEN bytes of each incoming frame to the compare cells as `char_in`/`char_valid`, and discards the rest of the frame. It sits between the prefix input byte stream and the array of `cr_prefix_fe_cmp` instances.

## Interface
- N_CMP, 16, number of compare cells driven
- PFX_LEN, 64, maximum bytes per frame presented to the cells
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_vld  in  1  input byte valid
- in_rdy  out  1  input byte accepted when in_vld & in_rdy
- in_data  in  8  input byte
- in_sof  in  1  first byte of frame
- in_eof  in  1  last byte of frame
- cfg_ld  in  1  pulse: start loading N_CMP entries into the shadow bank
- cfg_busy  out  1  loader active or swap pending
- cfg_rd_en  out  1  config memory read strobe
- cfg_rd_addr  out  clog2(N_CMP)  config entry index
- cfg_rd_data  in  12  {use_prior, no_delay, cmp_type[1:0], match_val[7:0]}; valid exactly 1 cycle after cfg_rd_en
- char_out  out  8  byte to all cells
- char_valid_out  out  1  byte valid to all cells
- match_val_out  out  N_CMP*8  active bank, cell i at [8i+7:8i]
- cmp_type_out  out  N_CMP*2  active bank
- use_prior_out  out  N_CMP  active bank
- no_delay_out  out  N_CMP  active bank
- pfx_cnt  out  clog2(PFX_LEN+1)  bytes fed in the current frame
- frame_done  out  1  one-cycle pulse per completed frame
- sof_err  out  1  one-cycle pulse when a non-SOF byte is dropped in F_IDLE

## Operation
- Loader FSM, states L_IDLE, L_RD, L_WAIT:
  - L_IDLE: on cfg_ld, set addr=0 and go to L_RD.
  - L_RD: cfg_rd_en=1 at addr. Next cycle the shadow entry is written at addr-1 if addr>0. addr increments. After addr=N_CMP-1, go to L_WAIT.
  - L_WAIT: capture the last entry, set cfg_pend=1, return to L_IDLE.
  - Exactly N_CMP reads per load, in ascending address order, no gaps.
- cfg_ld while cfg_busy is ignored. cfg_busy = (loader != L_IDLE) | cfg_pend.
- Swap: when cfg_pend=1 and the frame FSM is in F_IDLE, copy the whole shadow bank into the active bank in one cycle and clear cfg_pend. The active bank never changes while the frame FSM is in F_FEED or F_SKIP.
- Frame FSM, states F_IDLE, F_FEED, F_SKIP:
  - in_rdy = 0 in F_IDLE when cfg_busy; otherwise in_rdy = 1.
  - F_IDLE, accepted byte with sof: feed it and set pfx_cnt=1.
    - With eof on the same beat: frame_done, stay in F_IDLE.
    - Else if PFX_LEN==1: go to F_SKIP.
    - Else: go to F_FEED.
  - F_IDLE, accepted byte without sof: drop it, pulse sof_err, stay in F_IDLE.
  - F_FEED, accepted byte: feed it, pfx_cnt+1.
    - eof: frame_done, go to F_IDLE.
    - Else if pfx_cnt reaches PFX_LEN: go to F_SKIP.
  - F_SKIP, accepted byte: no feed. eof: frame_done, go to F_IDLE.
  - A sof inside F_FEED or F_SKIP is treated as a data byte. No error is raised.
- pfx_cnt holds its value after frame end and clears on the next accepted sof. It saturates at PFX_LEN.
- "Feed" means the byte is registered onto char_out with char_valid_out=1 on the next cycle. char_out holds its last value when char_valid_out=0.

## Timing
- Reset values: all outputs 0; both banks 0; cfg_pend 0; FSMs in L_IDLE and F_IDLE; cfg_rd_addr 0.
- Input beat accepted at cycle t appears on char_out/char_valid_out at t+1. Cell compare results appear at t+2.
- frame_done is asserted at t+1 for an eof beat accepted at t. It coincides with the last char_valid_out if that byte was fed.
- Load of N_CMP entries: cfg_ld at t, cfg_rd_en at t+1..t+N_CMP, cfg_pend=1 at t+N_CMP+2. If F_IDLE, the swap happens that cycle and new config is on the outputs at t+N_CMP+3.
- Full throughput: one byte per cycle, with no bubbles across frame boundaries when no swap is pending.
- Reset mid-load or mid-frame aborts immediately. The shadow bank contents and any partial frame are discarded.

## Structure
- Add to cr_prefixPKG:
  - `prefix_fe_cfg_t` packed struct matching the cfg_rd_data layout.
  - `fe_seq_frm_st_e` and `fe_seq_ld_st_e` enums.
  - Default constants for N_CMP and PFX_LEN.
- One sub-module, `cr_prefix_fe_cfg_bank`: holds the shadow and active banks, the load write port and the swap strobe. The frame FSM stays in the top level.

## Test plan
- Reset, then cfg_ld: expect 16 consecutive cfg_rd_en with addr 0..15. Active outputs update at t+19 to the memory contents, e.g. entry 3 = 0x2A5 gives match_val_out[31:24]=0xA5, cmp_type_out[7:6]=2.
- 100-byte frame with PFX_LEN=64: exactly 64 char_valid_out cycles, pfx_cnt=64, in_rdy stays high, one frame_done one cycle after the eof beat.
- Single-beat sof+eof byte 0x41: char_out=0x41 for 1 cycle, frame_done in the same cycle, pfx_cnt=1.
- cfg_ld issued mid-frame: active outputs unchanged until eof. Swap occurs in F_IDLE. in_rdy is low in F_IDLE until the swap, and the next sof is accepted on the cycle after the swap.
- Non-sof byte while idle: sof_err pulse, no char_valid_out. A second cfg_ld during the load produces no extra reads.
- Assert rst_n low at load entry 7: all outputs are 0 and the active bank still reads 0 after reset release.
